// File: rtl/sdnf_sweep_checker.sv
// Sweeps every input vector of a WIDTH-input combinational function, captures its
// truth table and compares it against a golden constant.
module sdnf_sweep_checker #(
    parameter int                      WIDTH    = 5,
    parameter logic [(2**WIDTH)-1:0]   EXPECTED = 32'hFFDD6AC4,
    parameter int                      SETTLE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [WIDTH-1:0]        dut_in,
    input  logic                    dut_f,
    output logic                    busy,
    output logic                    done,
    output logic [(2**WIDTH)-1:0]   truth,
    output logic                    pass,
    output logic [WIDTH:0]          mismatch_cnt,
    output logic [WIDTH-1:0]        first_err_idx,
    output logic                    err_valid
);
    // state  | meaning
    // IDLE   | waiting for start, dut_in = 0
    // DRIVE  | dut_in = idx, settling for SETTLE cycles
    // SAMPLE | capture dut_f for idx, advance or finish
    // DONE   | one-cycle done pulse, pass valid
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int                SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]     SETTLE_TC = SW'(SETTLE - 1);
    localparam logic [WIDTH-1:0]  IDX_LAST = '1;

    state_t            state;
    logic [WIDTH-1:0]  idx;
    logic [SW-1:0]     settle_cnt;
    logic              miss;
    logic [WIDTH:0]    cnt_nxt;

    assign miss    = dut_f ^ EXPECTED[idx];
    assign cnt_nxt = mismatch_cnt + {{WIDTH{1'b0}}, miss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            settle_cnt    <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            truth         <= '0;
            pass          <= 1'b0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            err_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    dut_in <= '0;
                    if (start) begin
                        truth         <= '0;
                        pass          <= 1'b0;
                        mismatch_cnt  <= '0;
                        first_err_idx <= '0;
                        err_valid     <= 1'b0;
                        idx           <= '0;
                        settle_cnt    <= SETTLE_TC;
                        busy          <= 1'b1;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == '0) state <= SAMPLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    truth[idx]   <= dut_f;
                    mismatch_cnt <= cnt_nxt;
                    if (miss && !err_valid) begin
                        first_err_idx <= idx;
                        err_valid     <= 1'b1;
                    end
                    if (idx == IDX_LAST) begin
                        // pass uses the updated count so it lines up with done
                        pass   <= (cnt_nxt == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        dut_in <= '0;
                        state  <= DONE;
                    end else begin
                        idx        <= idx + 1'b1;
                        dut_in     <= idx + 1'b1;
                        settle_cnt <= SETTLE_TC;
                        state      <= DRIVE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdnf_sweep_checker.sv
// Self-checking bench for sdnf_sweep_checker: table vectors, random functions
// against a truth-table model, and hand-written timing/reset sequences.
module tb_sdnf_sweep_checker;
    localparam logic [31:0] EXP = 32'hFFDD6AC4;

    typedef struct {
        logic [31:0] f;
        logic [31:0] truth;
        int          cnt;
        int          first;
        bit          errv;
        bit          pass;
    } vec_t;

    logic        clk = 0, rst = 0;
    logic        start_a = 0, start_b = 0;
    logic [31:0] fa = EXP, fb = EXP;
    logic [4:0]  dut_in_a, dut_in_b, first_a, first_b;
    logic        dut_f_a, dut_f_b, busy_a, busy_b, done_a, done_b;
    logic        pass_a, pass_b, errv_a, errv_b;
    logic [31:0] truth_a, truth_b;
    logic [5:0]  cnt_a, cnt_b;

    int checks = 0, failures = 0;

    assign dut_f_a = fa[dut_in_a];
    assign dut_f_b = fb[dut_in_b];

    always #5 clk = ~clk;

    sdnf_sweep_checker #(.WIDTH(5), .EXPECTED(EXP), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_f(dut_f_a),
        .busy(busy_a), .done(done_a), .truth(truth_a), .pass(pass_a),
        .mismatch_cnt(cnt_a), .first_err_idx(first_a), .err_valid(errv_a));

    sdnf_sweep_checker #(.WIDTH(5), .EXPECTED(EXP), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_f(dut_f_b),
        .busy(busy_b), .done(done_b), .truth(truth_b), .pass(pass_b),
        .mismatch_cnt(cnt_b), .first_err_idx(first_b), .err_valid(errv_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the captured table is just f; errors are the set bits of f ^ EXP.
    function automatic vec_t model(input logic [31:0] f);
        vec_t m;
        logic [31:0] diff;
        diff    = f ^ EXP;
        m.f     = f;
        m.truth = f;
        m.cnt   = $countones(diff);
        m.first = 0;
        for (int i = 31; i >= 0; i--) if (diff[i]) m.first = i;
        m.errv  = (diff != 0);
        m.pass  = (diff == 0);
        return m;
    endfunction

    task automatic check_a(input string tag, input vec_t e);
        chk({tag, "_truth"}, truth_a, e.truth);
        chk({tag, "_cnt"},   cnt_a,   e.cnt);
        chk({tag, "_first"}, first_a, e.first);
        chk({tag, "_errv"},  errv_a,  e.errv);
        chk({tag, "_pass"},  pass_a,  e.pass);
    endtask

    // Pulse start for one edge and return the cycle number in which done is seen.
    task automatic run_a(input string tag, output int cyc);
        @(negedge clk) start_a = 1;
        @(posedge clk); #1 start_a = 0;
        cyc = 1;
        while (!done_a && cyc < 400) begin
            @(posedge clk); #1 cyc++;
        end
        if (!done_a) chk({tag, "_timeout"}, 0, 1);
    endtask

    vec_t tbl[4];
    vec_t e;
    int   cyc, ndone, dcyc;

    initial begin
        tbl[0] = '{32'hFFDD6AC4, 32'hFFDD6AC4, 0,  0,  1'b0, 1'b1};
        tbl[1] = '{32'h00000000, 32'h00000000, 21, 2,  1'b1, 1'b0};
        tbl[2] = '{32'h7FDD6AC4, 32'h7FDD6AC4, 1,  31, 1'b1, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 11, 0,  1'b1, 1'b0};

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dut_in", dut_in_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_truth", truth_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_errv", errv_a, 0);
        @(negedge clk) rst = 0;

        // table vectors
        for (int t = 0; t < 4; t++) begin
            fa = tbl[t].f;
            run_a($sformatf("tbl%0d", t), cyc);
            chk($sformatf("tbl%0d_done_cycle", t), cyc, 65);
            chk($sformatf("tbl%0d_busy_at_done", t), busy_a, 0);
            check_a($sformatf("tbl%0d", t), tbl[t]);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_done_pulse", t), done_a, 0);
            repeat (3) @(posedge clk);
            #1 check_a($sformatf("tbl%0d_hold", t), tbl[t]);
        end

        // randomized functions, some near-golden
        for (int r = 0; r < 20; r++) begin
            if (r % 3 == 0) fa = EXP ^ (32'd1 << $urandom_range(31, 0));
            else            fa = $urandom;
            e = model(fa);
            run_a($sformatf("rnd%0d", r), cyc);
            chk($sformatf("rnd%0d_done_cycle", r), cyc, 65);
            check_a($sformatf("rnd%0d", r), e);
            @(posedge clk);
        end

        // start re-pulsed during the sweep and in DONE
        fa = EXP;
        @(negedge clk) start_a = 1;
        @(posedge clk); #1 start_a = 0;
        ndone = 0; dcyc = 0;
        for (int c = 1; c <= 72; c++) begin
            start_a = (c == 10 || c == 65);
            if (done_a) begin ndone++; dcyc = c; end
            if (c == 67) chk("repulse_busy67", busy_a, 0);
            @(posedge clk); #1;
        end
        start_a = 0;
        chk("repulse_ndone", ndone, 1);
        chk("repulse_dcyc", dcyc, 65);
        check_a("repulse", model(EXP));

        // start held high
        @(negedge clk) start_a = 1;
        @(posedge clk); #1;
        dcyc = 0;
        for (int c = 1; c <= 67; c++) begin
            if (done_a && dcyc == 0) dcyc = c;
            if (c == 66) chk("held_busy66", busy_a, 0);
            if (c == 67) chk("held_busy67", busy_a, 1);
            if (c < 67) begin @(posedge clk); #1; end
        end
        chk("held_dcyc", dcyc, 65);
        start_a = 0;

        // reset mid-sweep at idx 10
        rst = 1; #2 rst = 0;
        fa = EXP;
        @(negedge clk) start_a = 1;
        @(posedge clk); #1 start_a = 0;
        repeat (20) @(posedge clk);
        #1 chk("midrst_idx10", dut_in_a, 10);
        #2 rst = 1;
        #1;
        chk("midrst_dut_in", dut_in_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_truth", truth_a, 0);
        chk("midrst_cnt", cnt_a, 0);
        chk("midrst_first", first_a, 0);
        chk("midrst_errv", errv_a, 0);
        chk("midrst_pass", pass_a, 0);
        @(negedge clk) rst = 0;
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run_a("after_rst", cyc);
        chk("after_rst_done_cycle", cyc, 65);
        check_a("after_rst", model(EXP));

        // SETTLE=3 instance
        fb = EXP;
        @(negedge clk) start_b = 1;
        @(posedge clk); #1 start_b = 0;
        cyc = 1;
        while (!done_b && cyc < 400) begin
            if (cyc <= 128) chk($sformatf("s3_dut_in_c%0d", cyc), dut_in_b, (cyc - 1) / 4);
            @(posedge clk); #1 cyc++;
        end
        chk("s3_done_cycle", cyc, 129);
        chk("s3_truth", truth_b, EXP);
        chk("s3_cnt", cnt_b, 0);
        chk("s3_errv", errv_b, 0);
        chk("s3_pass", pass_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
